// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the MAC operand sequencer.
package mac_seq_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, RESULT} seq_state_t;

    localparam int MAC_LAT = 2;

endpackage

// File: rtl/mac_seq_fifo.sv
// Small synchronous FIFO holding one operand stream; head data is always visible.
module mac_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    // A full FIFO refuses a push even if a pop frees a slot this cycle.
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mac_operand_sequencer.sv
// Feeds one MAC lane: clears, streams VEC_LEN operand pairs, drains, returns the result.
// Optional MAC_SEQ_STALL_STATS_EN builds a saturating STREAM starvation counter.
module mac_operand_sequencer
    import mac_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LEN    = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    a_valid,
    input  logic [DATA_WIDTH-1:0]   a_data,
    output logic                    a_ready,
    input  logic                    b_valid,
    input  logic [DATA_WIDTH-1:0]   b_data,
    output logic                    b_ready,
    output logic                    mac_en,
    output logic                    mac_clr,
    output logic [DATA_WIDTH-1:0]   mac_a,
    output logic [DATA_WIDTH-1:0]   mac_b,
    input  logic [3*DATA_WIDTH-1:0] mac_cout,
    output logic                    res_valid,
    output logic [3*DATA_WIDTH-1:0] res_data,
    input  logic                    res_ready,
    output logic                    busy,
    output logic [15:0]             stall_cnt
);

    localparam int CW  = $clog2(VEC_LEN + 1);
    localparam int DCW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    seq_state_t            state, state_nxt;
    logic [CW-1:0]         issue_cnt;
    logic [DCW-1:0]        drain_cnt;
    logic                  a_full, a_empty, b_full, b_empty;
    logic [DATA_WIDTH-1:0] a_head, b_head;
    logic                  issue, last_issue, drain_done;

    assign a_ready    = !a_full;
    assign b_ready    = !b_full;
    assign busy       = (state != IDLE);
    assign issue      = (state == STREAM) && !a_empty && !b_empty;
    assign last_issue = issue && (issue_cnt == CW'(VEC_LEN - 1));
    assign drain_done = (drain_cnt == DCW'(MAC_LAT - 1));

    mac_seq_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clk(clk), .rst_n(rst_n), .push(a_valid && a_ready), .wdata(a_data),
        .pop(issue), .rdata(a_head), .full(a_full), .empty(a_empty)
    );

    mac_seq_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clk(clk), .rst_n(rst_n), .push(b_valid && b_ready), .wdata(b_data),
        .pop(issue), .rdata(b_head), .full(b_full), .empty(b_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)      state_nxt = CLEAR;
            CLEAR:                   state_nxt = STREAM;
            STREAM:  if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = RESULT;
            RESULT:  if (res_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // MAC controls are registered so the clear lands in the CLEAR cycle and
    // each operand pair reaches the MAC the cycle after its pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mac_clr   <= 1'b0;
            mac_en    <= 1'b0;
            mac_a     <= '0;
            mac_b     <= '0;
            issue_cnt <= '0;
            drain_cnt <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            mac_clr <= (state == IDLE) && start;
            mac_en  <= issue;
            if (issue) begin
                mac_a <= a_head;
                mac_b <= b_head;
            end
            if (state == CLEAR) issue_cnt <= '0;
            else if (issue)     issue_cnt <= issue_cnt + CW'(1);
            if (state == DRAIN) drain_cnt <= drain_cnt + DCW'(1);
            else                drain_cnt <= '0;
            if (state == DRAIN && drain_done) begin
                res_valid <= 1'b1;
                res_data  <= mac_cout;
            end else if (state == RESULT && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef MAC_SEQ_STALL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (state == STREAM && (a_empty || b_empty) && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`else
    assign stall_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed bench for mac_operand_sequencer with a behavioural accumulator standing in for the MAC.
module tb_mac_operand_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, a_valid = 1'b0, b_valid = 1'b0, res_ready = 1'b0;
    logic [7:0]  a_data = '0, b_data = '0;
    logic        a_ready, b_ready, mac_en, mac_clr, res_valid, busy;
    logic [7:0]  mac_a, mac_b;
    logic [23:0] mac_cout, res_data;
    logic [15:0] stall_cnt;

    logic        s8_start = 1'b0, a8_valid = 1'b0, b8_valid = 1'b0, r8_ready = 1'b0;
    logic [7:0]  a8_data = '0, b8_data = '0;
    logic        a8_ready, b8_ready, d8_en, d8_clr, d8_res_valid, d8_busy;
    logic [7:0]  d8_a, d8_b;
    logic [23:0] d8_cout, d8_res_data;
    logic [15:0] d8_stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_operand_sequencer #(.DATA_WIDTH(8), .VEC_LEN(4), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .mac_en(mac_en), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
        .mac_cout(mac_cout), .res_valid(res_valid), .res_data(res_data),
        .res_ready(res_ready), .busy(busy), .stall_cnt(stall_cnt)
    );

    mac_operand_sequencer #(.DATA_WIDTH(8), .VEC_LEN(8), .FIFO_DEPTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8_start),
        .a_valid(a8_valid), .a_data(a8_data), .a_ready(a8_ready),
        .b_valid(b8_valid), .b_data(b8_data), .b_ready(b8_ready),
        .mac_en(d8_en), .mac_clr(d8_clr), .mac_a(d8_a), .mac_b(d8_b),
        .mac_cout(d8_cout), .res_valid(d8_res_valid), .res_data(d8_res_data),
        .res_ready(r8_ready), .busy(d8_busy), .stall_cnt(d8_stall)
    );

    // MAC stand-in: accumulator visible the cycle after En
    always @(posedge clk) begin
        if (!rst_n || mac_clr) mac_cout <= '0;
        else if (mac_en)       mac_cout <= mac_cout + ({16'b0, mac_a} * {16'b0, mac_b});
        if (!rst_n || d8_clr)  d8_cout <= '0;
        else if (d8_en)        d8_cout <= d8_cout + ({16'b0, d8_a} * {16'b0, d8_b});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_pair(input logic do_a, input logic [7:0] av,
                             input logic do_b, input logic [7:0] bv);
        a_valid = do_a; a_data = av;
        b_valid = do_b; b_data = bv;
        step();
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    // Pulse start and return cycles until res_valid (99 on timeout).
    task automatic run_job(output int lat);
        lat = 99;
        start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (res_valid) begin
                lat = c;
                break;
            end
            step();
            start = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] clr_m, en_m, rv_m;
        logic [7:0]  a3, b3, a8, b8;
        logic        a9_acc, hold_ok, idle_ok;
        int          lat;
        logic [15:0] exp_stall;

`ifdef MAC_SEQ_STALL_STATS_EN
        exp_stall = 16'd6;
`else
        exp_stall = 16'd0;
`endif

        // Reset state
        step(); step();
        chk("rst_ctrl", {mac_en, mac_clr, res_valid, busy}, 0);
        chk("rst_ops", {mac_a, mac_b}, 0);
        chk("rst_res", res_data, 0);
        chk("rst_ready", {a_ready, b_ready}, 2'b11);
        chk("rst_stall", stall_cnt, 0);
        rst_n = 1'b1;
        step();

        // Basic job: A={1,2,3,4}, B={5,6,7,8} prefetched
        for (int i = 0; i < 4; i++) push_pair(1'b1, 8'(i + 1), 1'b1, 8'(i + 5));
        clr_m = '0; en_m = '0; rv_m = '0; a3 = '0; b3 = '0; a8 = '0; b8 = '0;
        start = 1'b1;
        for (int c = 0; c < 9; c++) begin
            clr_m[c] = mac_clr;
            en_m[c]  = mac_en;
            rv_m[c]  = res_valid;
            if (c == 3) begin a3 = mac_a; b3 = mac_b; end
            if (c == 8) begin a8 = mac_a; b8 = mac_b; end
            step();
            start = 1'b0;
        end
        chk("basic_clr_pulse", clr_m, 16'h0002);
        chk("basic_en_cycles", en_m, 16'h0078);
        chk("basic_res_valid_at8", rv_m, 16'h0100);
        chk("basic_first_ops", {a3, b3}, {8'd1, 8'd5});
        chk("basic_held_ops", {a8, b8}, {8'd4, 8'd8});
        chk("basic_res_data", res_data, 70);
        handshake();
        chk("basic_after_hs", {res_valid, busy}, 0);

        // Starvation: A preloaded, B trickled one per 3 cycles
        push_pair(1'b1, 8'd1, 1'b1, 8'd2);
        for (int i = 1; i < 4; i++) push_pair(1'b1, 8'(i + 1), 1'b0, 8'd0);
        en_m = '0; rv_m = '0;
        start = 1'b1;
        for (int c = 0; c < 16; c++) begin
            b_valid = (c == 4 || c == 7 || c == 10);
            b_data  = (c == 4) ? 8'd3 : (c == 7) ? 8'd4 : 8'd5;
            en_m[c] = mac_en;
            rv_m[c] = res_valid;
            step();
            start = 1'b0;
        end
        b_valid = 1'b0;
        chk("starve_en_cycles", en_m, 16'h1248);
        chk("starve_res_valid", rv_m, 16'hC000);
        chk("starve_res_data", res_data, 40);
        chk("starve_stall_cnt", stall_cnt, exp_stall);
        handshake();

        // Backpressure: 9 A pushes into an 8-deep FIFO while idle
        for (int i = 0; i < 9; i++) begin
            a_valid = 1'b1; a_data = 8'(i + 1);
            b_valid = (i < 4); b_data = 8'd1;
            chk($sformatf("bp_a_ready_%0d", i), a_ready, (i < 8));
            step();
        end
        b_valid = 1'b0;
        chk("bp_9th_held", a_ready, 0);
        a9_acc = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (res_valid) break;
            if (a_valid && a_ready) a9_acc = 1'b1;
            step();
            start = 1'b0;
            if (a9_acc) a_valid = 1'b0;
        end
        start = 1'b0; a_valid = 1'b0;
        chk("bp_9th_accepted", a9_acc, 1);
        chk("bp_res", {res_valid, res_data}, {1'b1, 24'd10});
        hold_ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            if (!(res_valid === 1'b1 && res_data === 24'd10)) hold_ok = 1'b0;
        end
        chk("bp_res_hold", hold_ok, 1);
        handshake();

        // Reset mid-STREAM after two issues (A holds 5..9, B gets two entries)
        push_pair(1'b0, 8'd0, 1'b1, 8'd1);
        push_pair(1'b0, 8'd0, 1'b1, 8'd1);
        start = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            start = 1'b0;
        end
        chk("mid_issue2", {mac_en, busy, mac_a}, {1'b1, 1'b1, 8'd6});
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {mac_en, mac_clr, res_valid, busy, mac_a, mac_b}, 0);
        chk("mid_rst_ready", {a_ready, b_ready}, 2'b11);
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 8; i++) push_pair(1'b1, 8'd1, 1'b1, 8'd1);
        run_job(lat);
        chk("fresh_latency", lat, 8);
        chk("fresh_res", res_data, 4);
        handshake();
        run_job(lat);
        chk("b2b_latency", lat, 8);
        chk("b2b_res", res_data, 4);
        handshake();

        // VEC_LEN=8 instance: all-255 operands, start pulse during STREAM
        for (int i = 0; i < 8; i++) begin
            a8_valid = 1'b1; a8_data = 8'hFF; b8_valid = 1'b1; b8_data = 8'hFF;
            step();
        end
        a8_valid = 1'b0; b8_valid = 1'b0;
        lat = 99;
        s8_start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (d8_res_valid) begin
                lat = c;
                break;
            end
            step();
            s8_start = (c + 1 == 4);
        end
        s8_start = 1'b0;
        chk("ovf_latency", lat, 12);
        chk("ovf_res", d8_res_data, 520200);
        r8_ready = 1'b1;
        step();
        r8_ready = 1'b0;
        idle_ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (d8_busy !== 1'b0 || d8_res_valid !== 1'b0) idle_ok = 1'b0;
            step();
        end
        chk("ovf_single_result", idle_ok, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
